button_input_ctrl: RTL

Front-end input controller for the clock/alarm display path. It synchronizes and debounces four raw push-buttons and runs the mode/edit state machine. It produces clock_set, alarm_set, location, alarm_location for segment_display, plus digit-increment and alarm-acknowledge pulses for the timekeeping core.

---
 rtl/button_input_ctrl_if.sv | 29 ++
 rtl/button_input_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_input_ctrl_if.sv
// Button/alarm inputs and mode/edit outputs of button_input_ctrl.
// The master side drives the raw buttons; the slave side is the controller.
interface button_input_ctrl_if;
    logic       BTN_MODE;
    logic       BTN_LEFT;
    logic       BTN_RIGHT;
    logic       BTN_UP;
    logic       alarm_ringing;
    logic       clock_set;
    logic       alarm_set;
    logic [1:0] location;
    logic [1:0] alarm_location;
    logic       inc_pulse;
    logic       inc_target;
    logic [1:0] inc_digit;
    logic       alarm_ack;

    modport master (
        output BTN_MODE, BTN_LEFT, BTN_RIGHT, BTN_UP, alarm_ringing,
        input  clock_set, alarm_set, location, alarm_location,
        input  inc_pulse, inc_target, inc_digit, alarm_ack
    );

    modport slave (
        input  BTN_MODE, BTN_LEFT, BTN_RIGHT, BTN_UP, alarm_ringing,
        output clock_set, alarm_set, location, alarm_location,
        output inc_pulse, inc_target, inc_digit, alarm_ack
    );
endinterface

// File: rtl/button_input_ctrl.sv
// Synchronize/debounce four buttons and run the NORMAL/CLOCK_SET/ALARM_SET edit FSM.
// Optional AUTO_REPEAT_EN macro: held UP auto-repeats inc_pulse in the set states.
module button_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic                MCLK,
    input  logic                RESETN,
    button_input_ctrl_if.slave  bus
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        CLOCK_SET = 2'd1,
        ALARM_SET = 2'd2
    } state_t;

    // Bit order doubles as priority: MODE(0) > LEFT(1) > RIGHT(2) > UP(3)
    logic [3:0]    raw;
    logic [3:0]    sync1, sync2, deb, deb_d;
    logic [CW-1:0] db_cnt [4];
    logic [3:0]    press;

    assign raw   = {bus.BTN_UP, bus.BTN_RIGHT, bus.BTN_LEFT, bus.BTN_MODE};
    assign press = deb & ~deb_d;

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t     state_q, state_d;
    logic [1:0] loc_q, loc_d, aloc_q, aloc_d;
    logic       inc_pulse_q, inc_pulse_d;
    logic       inc_target_q, inc_target_d;
    logic [1:0] inc_digit_q, inc_digit_d;
    logic       alarm_ack_q, alarm_ack_d;
    logic       clock_set_q, alarm_set_q;
    logic       mode_evt;
    logic       rpt_fire;

    assign mode_evt = press[0] && !bus.alarm_ringing;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_hold;

    // Counts cycles since the press (or last repeat); the first interval is REPEAT_DELAY
    assign rpt_hold = deb[3] && (state_q != NORMAL) && !bus.alarm_ringing && !mode_evt;
    assign rpt_fire = rpt_hold &&
                      (rpt_cnt == (rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!rpt_hold) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= RW'(1);
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end
`else
    logic unused_rpt_params;
    assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire          = 1'b0;
`endif

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= NORMAL;
            loc_q        <= '0;
            aloc_q       <= '0;
            inc_pulse_q  <= 1'b0;
            inc_target_q <= 1'b0;
            inc_digit_q  <= '0;
            alarm_ack_q  <= 1'b0;
            clock_set_q  <= 1'b0;
            alarm_set_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            loc_q        <= loc_d;
            aloc_q       <= aloc_d;
            inc_pulse_q  <= inc_pulse_d;
            inc_target_q <= inc_target_d;
            inc_digit_q  <= inc_digit_d;
            alarm_ack_q  <= alarm_ack_d;
            clock_set_q  <= (state_d == CLOCK_SET);
            alarm_set_q  <= (state_d == ALARM_SET);
        end
    end

    always_comb begin
        state_d      = state_q;
        loc_d        = loc_q;
        aloc_d       = aloc_q;
        inc_pulse_d  = 1'b0;
        inc_target_d = 1'b0;
        inc_digit_d  = '0;
        alarm_ack_d  = 1'b0;
        if (|press) begin
            // Only the highest-priority press is acted on; the others are dropped
            if (bus.alarm_ringing) begin
                alarm_ack_d = 1'b1;
            end else if (press[0]) begin
                case (state_q)
                    NORMAL: begin
                        state_d = CLOCK_SET;
                        loc_d   = '0;
                    end
                    CLOCK_SET: begin
                        state_d = ALARM_SET;
                        aloc_d  = '0;
                    end
                    default: state_d = NORMAL;
                endcase
            end else if (press[1]) begin
                if (state_q == CLOCK_SET)      loc_d  = loc_q - 2'd1;
                else if (state_q == ALARM_SET) aloc_d = aloc_q - 2'd1;
            end else if (press[2]) begin
                if (state_q == CLOCK_SET)      loc_d  = loc_q + 2'd1;
                else if (state_q == ALARM_SET) aloc_d = aloc_q + 2'd1;
            end else if (state_q != NORMAL) begin
                inc_pulse_d  = 1'b1;
                inc_target_d = (state_q == ALARM_SET);
                inc_digit_d  = (state_q == ALARM_SET) ? aloc_q : loc_q;
            end
        end else if (rpt_fire) begin
            inc_pulse_d  = 1'b1;
            inc_target_d = (state_q == ALARM_SET);
            inc_digit_d  = (state_q == ALARM_SET) ? aloc_q : loc_q;
        end
    end

    assign bus.clock_set      = clock_set_q;
    assign bus.alarm_set      = alarm_set_q;
    assign bus.location       = loc_q;
    assign bus.alarm_location = aloc_q;
    assign bus.inc_pulse      = inc_pulse_q;
    assign bus.inc_target     = inc_target_q;
    assign bus.inc_digit      = inc_digit_q;
    assign bus.alarm_ack      = alarm_ack_q;
endmodule
